// File: rtl/seg_digit_scanner.sv
// seg_digit_scanner
//   Time-multiplexed digit scanner for a common-anode seven-segment display.
//   Each digit gets one slot of REFRESH_DIV cycles. The first DEAD_CYCLES
//   cycles of a slot keep every anode off (anti-ghosting) and the rest light
//   the digit. New values are staged on i_load and only reach the displayed
//   (shadow) copy at a frame boundary or while idle, so a frame never tears.
//   Optional leading-zero blanking keeps the anodes of high zero digits off.
//
// Ports
//   i_clk        system clock, rising edge
//   i_rst_n      synchronous active-low reset
//   i_enable     scan enable; low forces the display dark (IDLE)
//   i_load       one-cycle strobe capturing i_value
//   i_value      packed digits, nibble k is digit k (digit 0 rightmost)
//   i_blank_lz   leading-zero blanking enable
//   o_data       nibble of the current digit for the segment decoder
//   o_an         active-low anode enables, bit k drives digit k
//   o_frame_done one-cycle pulse after the last digit slot completes
module seg_digit_scanner #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned DEAD_CYCLES = 1000
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_enable,
  input  logic                    i_load,
  input  logic [4*NUM_DIGITS-1:0] i_value,
  input  logic                    i_blank_lz,
  output logic [3:0]              o_data,
  output logic [NUM_DIGITS-1:0]   o_an,
  output logic                    o_frame_done
);

  localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned VW = 4 * NUM_DIGITS;

  localparam logic [PW-1:0] P_LAST    = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] DEAD_LAST = PW'(DEAD_CYCLES - 1);
  localparam logic [IW-1:0] I_LAST    = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DEAD = 2'd1,
    S_ON   = 2'd2
  } state_t;

  state_t                r_state;
  logic [PW-1:0]         r_presc;
  logic [IW-1:0]         r_idx;
  logic [VW-1:0]         r_stage;
  logic [VW-1:0]         r_shadow;
  logic                  r_pending;
  logic [3:0]            r_data;
  logic [NUM_DIGITS-1:0] r_an;
  logic                  r_frame_done;

  state_t                w_state_nxt;
  logic [PW-1:0]         w_presc_nxt;
  logic [IW-1:0]         w_idx_nxt;
  logic                  w_boundary;
  logic                  w_update;
  logic [VW-1:0]         w_stage_nxt;
  logic [VW-1:0]         w_shadow_nxt;
  logic                  w_pending_nxt;
  logic [3:0]            w_data_nxt;
  logic                  w_blank;
  logic                  w_zeros_above;
  logic [NUM_DIGITS-1:0] w_an_nxt;

  // Next-state: scan sequencing
  always_comb begin
    w_state_nxt = r_state;
    w_presc_nxt = r_presc;
    w_idx_nxt   = r_idx;
    w_boundary  = 1'b0;
    if (!i_enable) begin
      w_state_nxt = S_IDLE;
      w_presc_nxt = '0;
      w_idx_nxt   = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          w_state_nxt = S_DEAD;
          w_presc_nxt = '0;
          w_idx_nxt   = '0;
        end
        S_DEAD: begin
          w_presc_nxt = r_presc + 1'b1;
          if (r_presc == DEAD_LAST) w_state_nxt = S_ON;
        end
        S_ON: begin
          if (r_presc == P_LAST) begin
            w_presc_nxt = '0;
            w_state_nxt = S_DEAD;
            w_idx_nxt   = (r_idx == I_LAST) ? '0 : r_idx + 1'b1;
            w_boundary  = (r_idx == I_LAST);
          end else begin
            w_presc_nxt = r_presc + 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_presc_nxt = '0;
          w_idx_nxt   = '0;
        end
      endcase
    end
  end

  // Staging / shadow transfer. A load coinciding with an update point
  // bypasses staging so the new value is shown in the very next frame.
  always_comb begin
    w_update      = w_boundary || (r_state == S_IDLE);
    w_stage_nxt   = r_stage;
    w_shadow_nxt  = r_shadow;
    w_pending_nxt = r_pending;
    if (i_load && w_update) begin
      w_stage_nxt   = i_value;
      w_shadow_nxt  = i_value;
      w_pending_nxt = 1'b0;
    end else if (i_load) begin
      w_stage_nxt   = i_value;
      w_pending_nxt = 1'b1;
    end else if (w_update && r_pending) begin
      w_shadow_nxt  = r_stage;
      w_pending_nxt = 1'b0;
    end
  end

  // Outputs are registered from next-cycle state so they line up with it.
  // Blanking walks from the top digit down, tracking whether every nibble
  // at or above the current one is zero.
  always_comb begin
    w_data_nxt    = '0;
    w_blank       = 1'b0;
    w_zeros_above = 1'b1;
    w_an_nxt      = '1;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (w_idx_nxt == IW'(k)) w_data_nxt = w_shadow_nxt[4*k +: 4];
    end
    for (int unsigned j = 0; j < NUM_DIGITS - 1; j++) begin
      w_zeros_above = w_zeros_above && (w_shadow_nxt[4*(NUM_DIGITS-1-j) +: 4] == 4'h0);
      if (w_idx_nxt == IW'(NUM_DIGITS - 1 - j)) w_blank = i_blank_lz && w_zeros_above;
    end
    if (w_state_nxt == S_ON && !w_blank) begin
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
        if (w_idx_nxt == IW'(k)) w_an_nxt[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_presc      <= '0;
      r_idx        <= '0;
      r_stage      <= '0;
      r_shadow     <= '0;
      r_pending    <= 1'b0;
      r_data       <= '0;
      r_an         <= '1;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_presc      <= w_presc_nxt;
      r_idx        <= w_idx_nxt;
      r_stage      <= w_stage_nxt;
      r_shadow     <= w_shadow_nxt;
      r_pending    <= w_pending_nxt;
      r_data       <= w_data_nxt;
      r_an         <= w_an_nxt;
      r_frame_done <= w_boundary;
    end
  end

  assign o_data       = r_data;
  assign o_an         = r_an;
  assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_digit_scanner.sv
// Directed testbench for seg_digit_scanner with NUM_DIGITS=4,
// REFRESH_DIV=8, DEAD_CYCLES=2 (8-cycle slots: 2 dark, 6 lit; 32-cycle frames).
module tb_seg_digit_scanner;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        load;
  logic [15:0] value;
  logic        blank_lz;
  logic [3:0]  data;
  logic [3:0]  an;
  logic        frame_done;

  int unsigned n_checks;
  int unsigned n_errors;

  seg_digit_scanner #(
    .NUM_DIGITS (4),
    .REFRESH_DIV(8),
    .DEAD_CYCLES(2)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_enable    (enable),
    .i_load      (load),
    .i_value     (value),
    .i_blank_lz  (blank_lz),
    .o_data      (data),
    .o_an        (an),
    .o_frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks one full slot starting at its first (dark) cycle. Optionally
  // pulses i_load with v in cycle ld_at so it is sampled at that cycle's end.
  task automatic check_slot(input int unsigned dig, input logic [3:0] d, input bit lit,
                            input bit fd, input int ld_at, input logic [15:0] v);
    logic [3:0] exp_an;
    for (int i = 0; i < 8; i++) begin
      exp_an = (i >= 2 && lit) ? ~(4'b0001 << dig) : 4'hF;
      check_eq($sformatf("an d%0d c%0d", dig, i), {28'd0, an}, {28'd0, exp_an});
      check_eq($sformatf("data d%0d c%0d", dig, i), {28'd0, data}, {28'd0, d});
      check_eq($sformatf("fdone d%0d c%0d", dig, i), {31'd0, frame_done},
               {31'd0, (i == 0) ? fd : 1'b0});
      if (i == ld_at) begin
        load  = 1'b1;
        value = v;
      end
      step();
      load = 1'b0;
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    enable   = 1'b0;
    load     = 1'b0;
    value    = '0;
    blank_lz = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    check_eq("rst an", {28'd0, an}, 32'hF);
    check_eq("rst data", {28'd0, data}, 32'h0);
    check_eq("rst fdone", {31'd0, frame_done}, 32'h0);

    // 1: load while idle, then scan 1234
    load  = 1'b1;
    value = 16'h1234;
    step();
    load   = 1'b0;
    enable = 1'b1;
    step();
    check_slot(0, 4'h4, 1, 0, -1, 16'h0);
    check_slot(1, 4'h3, 1, 0, -1, 16'h0);
    check_slot(2, 4'h2, 1, 0, -1, 16'h0);
    check_slot(3, 4'h1, 1, 0, -1, 16'h0);
    check_slot(0, 4'h4, 1, 1, -1, 16'h0);

    // 2: load ABCD during digit 1; current frame unchanged
    check_slot(1, 4'h3, 1, 0, 0, 16'hABCD);
    check_slot(2, 4'h2, 1, 0, -1, 16'h0);
    check_slot(3, 4'h1, 1, 0, -1, 16'h0);
    check_slot(0, 4'hD, 1, 1, -1, 16'h0);
    check_slot(1, 4'hC, 1, 0, -1, 16'h0);
    check_slot(2, 4'hB, 1, 0, -1, 16'h0);
    // 3: load 0F0F sampled on the boundary edge
    check_slot(3, 4'hA, 1, 0, 7, 16'h0F0F);
    check_slot(0, 4'hF, 1, 1, -1, 16'h0);
    check_slot(1, 4'h0, 1, 0, -1, 16'h0);
    check_slot(2, 4'hF, 1, 0, -1, 16'h0);
    check_slot(3, 4'h0, 1, 0, -1, 16'h0);

    // 4: leading-zero blanking
    check_slot(0, 4'hF, 1, 1, 0, 16'h0050);
    check_slot(1, 4'h0, 1, 0, -1, 16'h0);
    check_slot(2, 4'hF, 1, 0, -1, 16'h0);
    check_slot(3, 4'h0, 1, 0, -1, 16'h0);
    blank_lz = 1'b1;
    check_slot(0, 4'h0, 1, 1, 0, 16'h0000);
    check_slot(1, 4'h5, 1, 0, -1, 16'h0);
    check_slot(2, 4'h0, 0, 0, -1, 16'h0);
    check_slot(3, 4'h0, 0, 0, -1, 16'h0);
    check_slot(0, 4'h0, 1, 1, -1, 16'h0);
    check_slot(1, 4'h0, 0, 0, -1, 16'h0);
    check_slot(2, 4'h0, 0, 0, -1, 16'h0);
    check_slot(3, 4'h0, 0, 0, -1, 16'h0);
    blank_lz = 1'b0;

    // 5: disable during ON of digit 2, load while idle, re-enable
    check_slot(0, 4'h0, 1, 1, -1, 16'h0);
    check_slot(1, 4'h0, 1, 0, -1, 16'h0);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("pre-dis an c%0d", i), {28'd0, an}, (i >= 2) ? 32'hB : 32'hF);
      if (i < 3) step();
    end
    enable = 1'b0;
    step();
    check_eq("dis an", {28'd0, an}, 32'hF);
    check_eq("dis fdone", {31'd0, frame_done}, 32'h0);
    load  = 1'b1;
    value = 16'h9876;
    step();
    load = 1'b0;
    step();
    check_eq("idle an", {28'd0, an}, 32'hF);
    enable = 1'b1;
    step();
    check_slot(0, 4'h6, 1, 0, -1, 16'h0);

    // 6: reset mid-ON of digit 1
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("pre-rst an c%0d", i), {28'd0, an}, (i >= 2) ? 32'hD : 32'hF);
      check_eq($sformatf("pre-rst data c%0d", i), {28'd0, data}, 32'h7);
      if (i < 3) step();
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_eq("mrst an", {28'd0, an}, 32'hF);
    check_eq("mrst data", {28'd0, data}, 32'h0);
    check_eq("mrst fdone", {31'd0, frame_done}, 32'h0);
    step();
    check_slot(0, 4'h0, 1, 0, -1, 16'h0);
    check_slot(1, 4'h0, 1, 0, -1, 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
